// File: rtl/hdb_encoder.sv
// AMI / HDBn line encoder: ZRUN-deep symbol delay line with back-filled B00V substitution.
// Optional violation counter is compiled in with HDB_VIOL_CNT_EN; otherwise viol_cnt reads zero.
module hdb_encoder #(
  parameter int ZRUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data,
  input  logic        data_en,
  input  logic        mode,
  output logic        P,
  output logic        N,
  output logic [15:0] viol_cnt
);

  localparam int ZW = $clog2(ZRUN);
  localparam logic [ZW-1:0] ZC_MAX = ZW'(ZRUN - 1);

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_MARK = 2'd1,
    SYM_B    = 2'd2,
    SYM_V    = 2'd3
  } sym_t;

  sym_t          d     [ZRUN];
  sym_t          d_nxt [ZRUN];
  logic [ZW-1:0] zc, zc_nxt;
  logic          par, par_nxt;
  logic          last_pol, last_pol_nxt;
  logic          p_nxt, n_nxt;
  logic          subst;

  assign subst = data_en && !data && mode && (zc == ZC_MAX);

  always_comb begin
    d_nxt        = d;
    zc_nxt       = zc;
    par_nxt      = par;
    last_pol_nxt = last_pol;
    p_nxt        = P;
    n_nxt        = N;
    if (data_en) begin
      // last_pol = 1 means the previous pulse went out on N
      case (d[0])
        SYM_MARK, SYM_B: begin
          p_nxt        = last_pol;
          n_nxt        = !last_pol;
          last_pol_nxt = !last_pol;
        end
        SYM_V: begin
          p_nxt = !last_pol;
          n_nxt = last_pol;
        end
        default: begin
          p_nxt = 1'b0;
          n_nxt = 1'b0;
        end
      endcase

      for (int i = 0; i < ZRUN - 1; i++) d_nxt[i] = d[i + 1];

      if (data) begin
        d_nxt[ZRUN-1] = SYM_MARK;
        par_nxt       = !par;
        zc_nxt        = '0;
      end else if (subst) begin
        // the slot about to be emitted holds the first zero of the run
        d_nxt[ZRUN-1] = SYM_V;
        if (!par) d_nxt[0] = SYM_B;
        zc_nxt  = '0;
        par_nxt = 1'b0;
      end else begin
        d_nxt[ZRUN-1] = SYM_ZERO;
        if (zc != ZC_MAX) zc_nxt = zc + ZW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ZRUN; i++) d[i] <= SYM_ZERO;
      zc       <= '0;
      par      <= 1'b0;
      last_pol <= 1'b1;
      P        <= 1'b0;
      N        <= 1'b0;
    end else begin
      d        <= d_nxt;
      zc       <= zc_nxt;
      par      <= par_nxt;
      last_pol <= last_pol_nxt;
      P        <= p_nxt;
      N        <= n_nxt;
    end
  end

`ifdef HDB_VIOL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      viol_cnt <= 16'h0000;
    end else if (subst && (viol_cnt != 16'hFFFF)) begin
      viol_cnt <= viol_cnt + 16'd1;
    end
  end
`else
  assign viol_cnt = 16'h0000;
`endif

endmodule

// File: doc/hdb_encoder.md
HDB_ENCODER -- requirements
Module: hdb_encoder

Interface
REQ-001 Parameter ZRUN, default 4, is the zero-run length that triggers substitution; legal range 3..8, and ZRUN=4 gives HDB3.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 data  input  1  NRZ data bit; sampled only when data_en=1.
REQ-005 data_en  input  1  bit strobe; each clk edge with data_en=1 is one "advance".
REQ-006 mode  input  1  selects coding: 0 = AMI, 1 = HDBn substitution.
REQ-007 P  output  1  positive-pulse rail, registered.
REQ-008 N  output  1  negative-pulse rail, registered.
REQ-009 viol_cnt  output  16  count of inserted V symbols.

Function
REQ-010 State SHALL be:
  - a delay line d[0..ZRUN-1], d[0] oldest; each entry is one symbol from {ZERO, MARK, B, V};
  - a zero-run counter zc, range 0..ZRUN-1;
  - a parity bit par, toggled by each MARK or B entered since the last V;
  - a polarity bit last_pol, 1 = last pulse was N.
REQ-011 With data_en=0, all state and P/N SHALL hold their values.
REQ-012 On each advance, the entry d[0] SHALL be emitted to P/N as follows:
  - ZERO: P=N=0.
  - MARK or B: pulse opposite to last_pol, then last_pol is updated.
  - V: pulse equal to last_pol; last_pol is unchanged.
REQ-013 On each advance, the line SHALL shift toward d[0], with the new symbol entering d[ZRUN-1].
REQ-014 Latency SHALL be exactly ZRUN advances: the symbol for the bit accepted at advance k appears on P/N at advance k+ZRUN.
REQ-015 data=1 SHALL enter a MARK, toggle par and clear zc.
REQ-016 data=0 with mode=0, or with zc<ZRUN-1, SHALL enter a ZERO and increment zc (mode=0: zc saturates at ZRUN-1).
REQ-017 data=0 with mode=1 and zc=ZRUN-1 SHALL substitute on the same edge:
  - new d[ZRUN-1] = V;
  - the post-shift d[0] = B if par=0, else it stays ZERO;
  - then zc=0 and par=0.
REQ-018 A B inserted by REQ-017 SHALL NOT toggle par, because par is cleared on that edge.
REQ-019 A mode change SHALL take effect at the next advance; symbols already in the delay line SHALL NOT be recoded.
REQ-020 viol_cnt SHALL increment on each substitution and saturate at 16'hFFFF.

Reset
REQ-021 When reset=0, SHALL asynchronously set:
  - every d entry = ZERO;
  - zc=0, par=0;
  - last_pol=1, so the first pulse goes on P;
  - P=0, N=0, viol_cnt=0.
REQ-022 Reset mid-stream SHALL discard all pending symbols; the first ZRUN advances after reset SHALL emit ZERO.
REQ-023 Zeros present in the line at reset SHALL NOT count toward zc.

Configuration
REQ-024 Macro HDB_VIOL_CNT_EN:
  - defined: the viol_cnt counter per REQ-020 is compiled in;
  - undefined: the counter logic is removed and viol_cnt is tied to 16'h0000;
  - P/N behaviour SHALL be identical in both builds.

Verification
REQ-025 ZRUN=4, mode=1, data_en=1 continuous, data 1,1,1 after reset -> four ZERO cycles, then P, N, P.
REQ-026 Data 1,0,0,0,0 (par odd) -> P, 0, 0, 0, P (000V, V same polarity as last pulse); viol_cnt=1.
REQ-027 Data 1,1,0,0,0,0 (par even) -> P, N, P, 0, 0, P (B00V); viol_cnt=1.
REQ-028 mode=0, data 1 then eight 0s -> P then eight ZERO; viol_cnt stays 0.
REQ-029 data_en pulsed every 3rd cycle with data 1,1 -> P/N hold between strobes; pulses appear only on strobe edges, latency 4 strobes.
REQ-030 Three substitutions, then reset asserted mid-run:
  - with HDB_VIOL_CNT_EN: viol_cnt reads 3 before reset and 0 after;
  - without the macro: viol_cnt stays 0 throughout.
